// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg: shared encodings for the UART receive path.
package uart_receiver_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic PAR_ODD  = 1'b0;
    localparam logic PAR_EVEN = 1'b1;
    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;
endpackage

// File: rtl/uart_receiver_parity.sv
// uart_parity_bit_compute: running parity over the data bits of one frame.
module uart_parity_bit_compute
    import uart_receiver_pkg::*;
(
    input  logic clk_i,
    input  logic rstn_i,
    input  logic soft_rst_i,
    input  logic valid_i,
    input  logic data_i,
    input  logic mode_i,
    output logic parity_o
);
    logic acc_q, acc_d;

    assign acc_d    = soft_rst_i ? 1'b0 : acc_q ^ (valid_i & data_i);
    assign parity_o = (mode_i == PAR_EVEN) ? acc_q : ~acc_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) acc_q <= 1'b0;
        else         acc_q <= acc_d;
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: mid-bit sampling UART deserialiser with runtime parity/stop-bit
// configuration, one-cycle valid pulse with parity and framing error flags.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int DIV_SIZE  = 16,
    parameter int DATA_UART = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 en_i,
    input  logic                 stop_bits_i,
    input  logic                 parity_bit_i,
    input  logic                 parity_bit_mode_i,
    input  logic [DIV_SIZE-1:0]  baud_div_i,
    input  logic                 rx_i,
    output logic [DATA_UART-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);
    localparam int BW = $clog2(DATA_UART + 1);

    logic                 rx_meta_q, rx_s, rx_q;
    logic [2:0]           state_q, state_d;
    logic [DIV_SIZE-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_UART-1:0] shift_q, shift_d, data_q, data_d;
    logic                 par_pend_q, par_pend_d, frm_pend_q, frm_pend_d;
    logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 tick, par_exp;

    assign tick         = cnt_q == baud_div_i;
    assign busy_o       = state_q != ST_IDLE;
    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;

    uart_parity_bit_compute u_parity (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .soft_rst_i (state_q == ST_IDLE),
        .valid_i    (state_q == ST_DATA && tick),
        .data_i     (rx_s),
        .mode_i     (parity_bit_mode_i),
        .parity_o   (par_exp)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        par_pend_d = par_pend_q;
        frm_pend_d = frm_pend_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                // Edge-triggered so a line held low (break) never retriggers
                if (en_i && rx_q && !rx_s) state_d = ST_START;
            end
            ST_START: if (cnt_q == (baud_div_i >> 1)) begin
                cnt_d   = '0;
                state_d = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (tick) begin
                cnt_d     = '0;
                shift_d   = {rx_s, shift_q[DATA_UART-1:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BW'(DATA_UART - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = parity_bit_i ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (tick) begin
                cnt_d      = '0;
                par_pend_d = rx_s != par_exp;
                state_d    = ST_STOP;
            end
            ST_STOP: if (tick) begin
                cnt_d      = '0;
                stop_cnt_d = ~stop_cnt_q;
                frm_pend_d = frm_pend_q | ~rx_s;
                if (stop_cnt_q == (stop_bits_i == STOP_TWO)) begin
                    state_d    = ST_IDLE;
                    stop_cnt_d = 1'b0;
                    valid_d    = 1'b1;
                    data_d     = shift_q;
                    perr_d     = par_pend_q & parity_bit_i;
                    ferr_d     = frm_pend_q | ~rx_s;
                    par_pend_d = 1'b0;
                    frm_pend_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                par_pend_d = 1'b0;
                frm_pend_d = 1'b0;
                perr_d     = 1'b0;
                ferr_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_meta_q  <= 1'b1;
            rx_s       <= 1'b1;
            rx_q       <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            par_pend_q <= 1'b0;
            frm_pend_q <= 1'b0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_s       <= rx_meta_q;
            rx_q       <= rx_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            par_pend_q <= par_pend_d;
            frm_pend_q <= frm_pend_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: serial frames driven onto rx_i, delivered words checked
// against a frame-level scoreboard built from the line bits the bench sends.
module tb_uart_receiver;
    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        en_i = 1'b1;
    logic        stop_bits_i = 1'b0;
    logic        parity_bit_i = 1'b0;
    logic        parity_bit_mode_i = 1'b0;
    logic [15:0] baud_div_i = 16'd15;
    logic        rx_i = 1'b1;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, parity_err_o, frame_err_o, busy_o;

    always #5 clk = ~clk;

    uart_receiver #(.DIV_SIZE(16), .DATA_UART(8)) dut (
        .clk_i             (clk),
        .rstn_i            (rstn_i),
        .en_i              (en_i),
        .stop_bits_i       (stop_bits_i),
        .parity_bit_i      (parity_bit_i),
        .parity_bit_mode_i (parity_bit_mode_i),
        .baud_div_i        (baud_div_i),
        .rx_i              (rx_i),
        .rx_data_o         (rx_data_o),
        .rx_valid_o        (rx_valid_o),
        .parity_err_o      (parity_err_o),
        .frame_err_o       (frame_err_o),
        .busy_o            (busy_o)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_valid = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] last_d = 8'h00;
    logic       last_pe = 1'b0;
    logic       last_fe = 1'b0;
    logic       prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle output checker driven by the scoreboard
    always @(negedge clk) begin
        if (!rstn_i) begin
            chk("rst_data", 32'(rx_data_o), 0);
            chk("rst_valid", 32'(rx_valid_o), 0);
            chk("rst_perr", 32'(parity_err_o), 0);
            chk("rst_ferr", 32'(frame_err_o), 0);
            chk("rst_busy", 32'(busy_o), 0);
            held = 8'h00;
            prev_valid = 1'b0;
        end else begin
            if (rx_valid_o) begin
                exp_t e;
                chk("pulse_width", 32'(prev_valid), 0);
                chk("valid_busy", 32'(busy_o), 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: got data %0h, expected no frame at %0t", rx_data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 32'(rx_data_o), 32'(e.d));
                    chk("perr", 32'(parity_err_o), 32'(e.pe));
                    chk("ferr", 32'(frame_err_o), 32'(e.fe));
                    held = e.d;
                end
                last_d = rx_data_o;
                last_pe = parity_err_o;
                last_fe = frame_err_o;
                n_valid++;
            end else begin
                chk("data_hold", 32'(rx_data_o), 32'(held));
            end
            prev_valid = rx_valid_o;
        end
    end

    function automatic logic par_of(input logic [7:0] d, input logic even);
        return even ? ^d : ~^d;
    endfunction

    task automatic drive_bit(input logic v);
        rx_i = v;
        repeat (int'(baud_div_i) + 1) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic pb, input logic s0, input logic s1,
                        input bit expect_it, input int gap);
        exp_t e;
        if (expect_it) begin
            e.d  = d;
            e.pe = parity_bit_i && ((($countones(d) + int'(pb)) % 2) != (parity_bit_mode_i ? 0 : 1));
            e.fe = !s0 || (stop_bits_i && !s1);
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (parity_bit_i) drive_bit(pb);
        drive_bit(s0);
        if (stop_bits_i) drive_bit(s1);
        for (int i = 0; i < gap; i++) drive_bit(1'b1);
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic cfg(input int bd, input logic p, input logic m, input logic s2);
        baud_div_i = 16'(bd);
        parity_bit_i = p;
        parity_bit_mode_i = m;
        stop_bits_i = s2;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int nv;
        repeat (3) @(posedge clk);
        #1;
        rstn_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy_o), 0);

        // 8N1 0xA5
        cfg(15, 0, 0, 0);
        send(8'hA5, 1'b0, 1'b1, 1'b1, 1, 1);
        wait_drain(300);
        chk("a5_count", 32'(n_valid), 1);
        chk("a5_data", 32'(last_d), 32'h A5);
        chk("a5_perr", 32'(last_pe), 0);
        chk("a5_ferr", 32'(last_fe), 0);

        // 8E1 / 8O1 parity on 0x0F
        cfg(15, 1, 1, 0);
        send(8'h0F, 1'b1, 1'b1, 1'b1, 1, 1);
        wait_drain(300);
        chk("e1_bad_data", 32'(last_d), 32'h0F);
        chk("e1_bad_perr", 32'(last_pe), 1);
        send(8'h0F, 1'b0, 1'b1, 1'b1, 1, 1);
        wait_drain(300);
        chk("e1_ok_perr", 32'(last_pe), 0);
        cfg(15, 1, 0, 0);
        send(8'h0F, 1'b1, 1'b1, 1'b1, 1, 1);
        wait_drain(300);
        chk("o1_ok_perr", 32'(last_pe), 0);

        // 8N2 with low second stop bit, then a 40-bit break
        cfg(15, 0, 0, 1);
        nv = n_valid;
        send(8'h96, 1'b0, 1'b1, 1'b0, 1, 0);
        rx_i = 1'b0;
        repeat (40 * 16) @(posedge clk);
        #1;
        wait_drain(300);
        chk("break_data", 32'(last_d), 32'h96);
        chk("break_ferr", 32'(last_fe), 1);
        chk("break_count", 32'(n_valid), 32'(nv + 1));
        drive_bit(1'b1);
        drive_bit(1'b1);

        // 4-cycle glitch, then a good frame
        cfg(15, 0, 0, 0);
        nv = n_valid;
        rx_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_i = 1'b1;
        chk("glitch_busy_hi", 32'(busy_o), 1);
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_busy_lo", 32'(busy_o), 0);
        chk("glitch_count", 32'(n_valid), 32'(nv));
        send(8'h3C, 1'b0, 1'b1, 1'b1, 1, 1);
        wait_drain(300);
        chk("3c_data", 32'(last_d), 32'h3C);

        // 8E2 back-to-back at baud_div 7
        cfg(7, 1, 1, 1);
        nv = n_valid;
        send(8'h00, 1'b0, 1'b1, 1'b1, 1, 0);
        send(8'hFF, 1'b0, 1'b1, 1'b1, 1, 0);
        send(8'h55, 1'b0, 1'b1, 1'b1, 1, 1);
        wait_drain(300);
        chk("b2b_count", 32'(n_valid), 32'(nv + 3));
        chk("b2b_last", 32'(last_d), 32'h55);
        chk("b2b_perr", 32'(last_pe), 0);

        // Receiver disabled: frames ignored
        en_i = 1'b0;
        send(8'hC3, 1'b0, 1'b1, 1'b1, 0, 1);
        send(8'h18, 1'b0, 1'b1, 1'b1, 0, 1);
        en_i = 1'b1;
        chk("en_busy", 32'(busy_o), 0);
        chk("en_count", 32'(n_valid), 32'(nv + 3));

        // Reset in the middle of data bit 4
        cfg(15, 0, 0, 0);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i == 0);
        rx_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rstn_i = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_data", 32'(rx_data_o), 0);
        chk("mid_rst_valid", 32'(rx_valid_o), 0);
        rx_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rstn_i = 1'b1;
        drive_bit(1'b1);
        send(8'h81, 1'b0, 1'b1, 1'b1, 1, 1);
        wait_drain(300);
        chk("81_data", 32'(last_d), 32'h81);

        // Randomized configurations and frames
        for (int b = 0; b < 12; b++) begin
            logic p, m, s2;
            p = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            cfg($urandom_range(1, 12), p, m, s2);
            for (int f = 0; f < 4; f++) begin
                logic [7:0] d;
                logic pb, s0, s1, last;
                d = 8'($urandom);
                pb = par_of(d, m) ^ ($urandom_range(0, 3) == 0);
                s0 = $urandom_range(0, 5) != 0;
                s1 = $urandom_range(0, 5) != 0;
                last = s2 ? s1 : s0;
                send(d, pb, s0, s1, 1, last ? $urandom_range(0, 1) : 1);
            end
            wait_drain(400);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART RX path of the AXI-lite UART core. It deserialises the rx line into DATA_UART-bit words, LSB first, using the same runtime frame configuration as the TX path: baud divisor, optional parity with mode, and 1 or 2 stop bits. Each completed frame produces a single-cycle valid pulse with parity and framing error flags, which the controller latches into the RX FIFO/status registers. It runs in the fixed UART clock domain.

Parameters:
DIV_SIZE, 16, width of the baud divisor; bit period = baud_div_i+1 clk_i cycles
DATA_UART, 8, data bits per frame

Ports:
clk_i  in  1  clock; single clock domain
rstn_i  in  1  reset, asynchronous, active-low
en_i  in  1  receiver enable; gates start-bit detection only
stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits
parity_bit_i  in  1  1 = parity bit present after data
parity_bit_mode_i  in  1  0 = odd, 1 = even
baud_div_i  in  DIV_SIZE  bit period minus one, in clk_i cycles
rx_i  in  1  serial input, asynchronous to clk_i, idle high
rx_data_o  out  DATA_UART  received word, held until the next frame completes
rx_valid_o  out  1  one-cycle pulse when a frame completes
parity_err_o  out  1  parity mismatch for the frame flagged by rx_valid_o
frame_err_o  out  1  a stop bit was sampled low for the flagged frame
busy_o  out  1  high from start-bit detection until the frame completes or is aborted

Behaviour:
- rx_i passes through a 2-FF synchroniser (reset value 1). All logic uses the synchronised rx_s and its previous value rx_q.
- Reset values: rx_data_o=0, rx_valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0, state=Idle, counter=0, bit count=0, stop count=0.
- States:
  - Idle -> Start: on en_i & rx_q & ~rx_s (falling edge only; a line held low never retriggers). Counter cleared, busy_o set next cycle.
  - Start: counter increments. When counter == baud_div_i>>1:
    - rx_s == 0: go to Data, counter cleared.
    - rx_s == 1: glitch; go to Idle, busy_o cleared, no valid pulse.
  - Data: counter increments. When counter == baud_div_i: sample rx_s into shift register MSB (shift right), counter cleared, bit count +1. After DATA_UART samples, go to Parity if parity_bit_i, else Stop.
  - Parity: when counter == baud_div_i, sample rx_s.
    - Expected bit = XOR(data) for even, ~XOR(data) for odd.
    - Mismatch sets the pending parity error. Go to Stop.
  - Stop: when counter == baud_div_i, sample rx_s; a 0 sets the pending frame error. Stop count +1. When stop count reaches 1 (stop_bits_i=0) or 2 (stop_bits_i=1), the frame completes.
  - Frame completion (next cycle): rx_data_o = shift register, parity_err_o/frame_err_o = pending flags (parity_err_o forced 0 if parity disabled), rx_valid_o=1 for exactly one cycle, busy_o=0, go to Idle, pending flags cleared.
- Sampling is mid-bit: start bit sampled at half period, subsequent bits every baud_div_i+1 cycles. This matches the TX bit period exactly.
- Configuration inputs are sampled live. Changing them mid-frame is undefined; the controller changes them only while busy_o=0.
- en_i deasserted mid-frame: the current frame completes normally; no new start is accepted.
- Frame error: data is still delivered with frame_err_o=1. A break (line stays low) produces one frame_err frame, then waits in Idle for a high->low edge.
- baud_div_i=0: 1-cycle bits, start sampled at counter 0; legal.
- Illegal state encodings recover to Idle with all flags cleared.
- Reset asserted mid-frame: everything returns to reset values immediately, with no valid pulse.

Decomposition:
- Shared package/header: state encodings (Idle, Start, Data, Parity, Stop), parity mode constants (ODD=0, EVEN=1), stop-bit constants.
- Sub-module: reuse uart_parity_bit_compute, fed by the sampled data bit with valid asserted per data sample and soft reset asserted in Idle. Its output is compared to the sampled parity bit.
- The synchroniser is inline; no separate module is needed.

Test Plan:
- baud_div_i=15, 8N1, line frame 0xA5 -> after the stop-bit sample, rx_valid_o pulses once, rx_data_o=0xA5, parity_err_o=0, frame_err_o=0, busy_o falls the same cycle.
- 8E1, data 0x0F with parity bit 1 -> rx_data_o=0x0F, parity_err_o=1. Same data with parity bit 0 -> parity_err_o=0. 8O1 with 0x0F and parity 1 -> no error.
- 8N2, second stop bit driven 0 -> rx_data_o correct, frame_err_o=1. Line then held low 40 bit times -> no further rx_valid_o until the line returns high and falls again.
- rx_i low for 4 cycles only (baud_div_i=15) -> busy_o rises then falls, no rx_valid_o; a following valid frame 0x3C is received correctly.
- Loopback from uart_transmitter, baud_div_i=7, 8E2: back-to-back 0x00, 0xFF, 0x55 -> three rx_valid_o pulses, matching data, no errors. en_i low during idle -> frames ignored.
- rstn_i asserted mid-data-bit 4 -> all outputs 0 and busy_o=0 immediately; after release, next frame 0x81 is received correctly.
